// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter slice: default widths, server FSM
// state encoding and the read/write encoding of wr_ni.
package bus_arbiter_pkg;

    localparam int unsigned SRV_DATA_WIDTH = 8;
    localparam int unsigned SRV_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } srv_state_e;

    localparam logic WR_NI_RD = 1'b1;
    localparam logic WR_NI_WR = 1'b0;

endpackage

// File: rtl/bus_server_regfile.sv
// Storage array for the bus server: synchronous write, registered read and an
// asynchronous active-low clear of every word and of the read register.
module bus_server_regfile #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned LP_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [LP_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            // Read register holds its value across writes and idle cycles.
            if (i_re) begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_server_memory.sv
// Server-side responder for the four-client bus arbiter: wait states, storage
// access and four-phase rq/ack. Wait states are built only with SERVER_WAIT_STATES_EN.
module bus_server_memory
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SRV_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = SRV_ADDR_WIDTH,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] server_address,
    input  logic                  server_rq,
    input  logic                  server_wr_ni,
    input  logic [DATA_WIDTH-1:0] server_dataW,
    output logic                  server_ack,
    output logic [DATA_WIDTH-1:0] server_dataR,
    output logic                  server_err
);

    srv_state_e            r_state;
    srv_state_e            w_state_nxt;
    logic                  w_access;
    logic                  w_acc_wr_ni;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;

`ifdef SERVER_WAIT_STATES_EN
    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr_ni;
    logic [DATA_WIDTH-1:0] r_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wr_ni <= WR_NI_RD;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            if (w_capture) begin
                r_addr  <= server_address;
                r_wr_ni <= server_wr_ni;
                r_wdata <= server_dataW;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        w_acc_addr  = r_addr;
        w_acc_wr_ni = r_wr_ni;
        w_acc_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                // A zero-wait access happens on the capturing edge, so it
                // must use the live bus rather than the not-yet-loaded latches.
                w_acc_addr  = server_address;
                w_acc_wr_ni = server_wr_ni;
                w_acc_wdata = server_dataW;
                if (server_rq) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_cnt_nxt   = LP_WAIT_LOAD;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!server_rq) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                if (!server_rq) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign server_err = r_err;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        w_acc_addr  = server_address;
        w_acc_wr_ni = server_wr_ni;
        w_acc_wdata = server_dataW;
        case (r_state)
            S_IDLE: begin
                if (server_rq) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!server_rq) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign server_err = 1'b0;
`endif

    assign server_ack = (r_state == S_ACK);

    bus_server_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_access && (w_acc_wr_ni == WR_NI_WR)),
        .i_re    (w_access && (w_acc_wr_ni == WR_NI_RD)),
        .i_addr  (w_acc_addr),
        .i_wdata (w_acc_wdata),
        .o_rdata (server_dataR)
    );

endmodule

// File: tb/tb_bus_server_memory.sv
// Self-checking bench for bus_server_memory: table of directed transactions
// plus hand-written abort, bus-change and reset-in-ACK sequences.
module tb_bus_server_memory;

`ifdef SERVER_WAIT_STATES_EN
    localparam int         LAT       = 2;
    localparam logic [7:0] ABORT_MEM = 8'h00;
    localparam logic       ABORT_ERR = 1'b1;
`else
    localparam int         LAT       = 0;
    localparam logic [7:0] ABORT_MEM = 8'h3C;
    localparam logic       ABORT_ERR = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] server_address;
    logic       server_rq;
    logic       server_wr_ni;
    logic [7:0] server_dataW;
    logic       server_ack;
    logic [7:0] server_dataR;
    logic       server_err;

    int n_checks;
    int n_fail;

    bus_server_memory #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .WAIT_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .server_address (server_address),
        .server_rq      (server_rq),
        .server_wr_ni   (server_wr_ni),
        .server_dataW   (server_dataW),
        .server_ack     (server_ack),
        .server_dataR   (server_dataR),
        .server_err     (server_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_ni;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] exp_r;
    } txn_t;

    txn_t vec [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input string tag, input logic wr_ni, input logic [3:0] addr,
                           input logic [7:0] wdata, input int hold, input logic [7:0] exp_r);
        int lat;
        @(negedge clk);
        server_rq      = 1'b1;
        server_wr_ni   = wr_ni;
        server_address = addr;
        server_dataW   = wdata;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (server_ack) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " dataR"}, server_dataR, exp_r);
        check({tag, " err"}, server_err, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, " ack held"}, server_ack, 1);
        end
        @(negedge clk);
        server_rq = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " ack release"}, server_ack, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vec[0] = '{1'b1, 4'h3, 8'h00, 0, 8'h00};
        vec[1] = '{1'b0, 4'h7, 8'hA5, 0, 8'h00};
        vec[2] = '{1'b1, 4'h7, 8'h00, 5, 8'hA5};
        vec[3] = '{1'b0, 4'h0, 8'h5C, 2, 8'hA5};
        vec[4] = '{1'b1, 4'h0, 8'h00, 0, 8'h5C};
        vec[5] = '{1'b0, 4'hF, 8'hFF, 0, 8'h5C};
        vec[6] = '{1'b1, 4'hF, 8'h00, 1, 8'hFF};
        vec[7] = '{1'b1, 4'h7, 8'h00, 0, 8'hA5};
        vec[8] = '{1'b0, 4'h7, 8'h01, 0, 8'hA5};
        vec[9] = '{1'b1, 4'h7, 8'h00, 0, 8'h01};

        reset          = 1'b0;
        server_rq      = 1'b0;
        server_wr_ni   = 1'b1;
        server_address = 4'h0;
        server_dataW   = 8'h00;
        repeat (2) @(negedge clk);
        check("reset ack", server_ack, 0);
        check("reset dataR", server_dataR, 0);
        check("reset err", server_err, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vec[i].wr_ni, vec[i].addr, vec[i].wdata,
                    vec[i].hold, vec[i].exp_r);
        end

        // Abort: rq dropped one edge after capture.
        @(negedge clk);
        server_rq      = 1'b1;
        server_wr_ni   = 1'b0;
        server_address = 4'h2;
        server_dataW   = 8'h3C;
        @(posedge clk);
        #1;
        @(negedge clk);
        server_rq = 1'b0;
        @(posedge clk);
        #1;
        check("abort err", server_err, ABORT_ERR);
        check("abort ack", server_ack, 0);
        @(posedge clk);
        #1;
        check("abort err pulse end", server_err, 0);
        run_txn("abort readback", 1'b1, 4'h2, 8'h00, 0, ABORT_MEM);

        // Bus changes after capture must be ignored.
        @(negedge clk);
        server_rq      = 1'b1;
        server_wr_ni   = 1'b0;
        server_address = 4'h1;
        server_dataW   = 8'h11;
        @(posedge clk);
        #1;
        server_address = 4'h9;
        server_dataW   = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            if (server_ack) break;
            @(posedge clk);
            #1;
        end
        check("buschg ack", server_ack, 1);
        @(negedge clk);
        server_rq = 1'b0;
        @(posedge clk);
        #1;
        run_txn("buschg rd1", 1'b1, 4'h1, 8'h00, 0, 8'h11);
        run_txn("buschg rd9", 1'b1, 4'h9, 8'h00, 0, 8'h00);

        // Asynchronous reset while in ACK.
        @(negedge clk);
        server_rq      = 1'b1;
        server_wr_ni   = 1'b0;
        server_address = 4'hF;
        server_dataW   = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (server_ack) break;
        end
        check("rstack ack before", server_ack, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rstack ack", server_ack, 0);
        check("rstack dataR", server_dataR, 0);
        check("rstack err", server_err, 0);
        server_rq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_txn("rstack rdF", 1'b1, 4'hF, 8'h00, 0, 8'h00);
        run_txn("rstack rd7", 1'b1, 4'h7, 8'h00, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_server_memory.md
# bus_server_memory

Server-side responder for the four-client bus arbiter. It sits directly downstream of the arbiter on the server interface: it accepts the arbitrated request (address, read/write, write data), holds it for a fixed number of wait states, performs the access on an internal 2^ADDR_WIDTH x DATA_WIDTH storage array, and completes the four-phase rq/ack handshake. It is the target that makes arbiter traffic observable end-to-end by the bus monitor.

## Interface
- DATA_WIDTH, 8, width of server_dataW / server_dataR and of each storage word
- ADDR_WIDTH, 4, address width; storage depth is 2^ADDR_WIDTH words
- WAIT_CYCLES, 2, wait states inserted before ack; legal range 0..15; ignored when wait states are compiled out

- clk  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-low; asserting it immediately forces the reset state
- server_address  input  ADDR_WIDTH  word address, sampled with the request
- server_rq  input  1  request from arbiter, held high until ack seen
- server_wr_ni  input  1  1 = read, 0 = write
- server_dataW  input  DATA_WIDTH  write data, sampled with the request
- server_ack  output  1  request served; held high until server_rq falls
- server_dataR  output  DATA_WIDTH  read data, valid while server_ack is high after a read
- server_err  output  1  one-cycle pulse on protocol violation

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: on posedge with server_rq=1, latch address, wr_ni, dataW into internal registers. If wait count is 0 go to ACK and perform the access on that edge; otherwise load wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: counter decrements each edge; on the edge where counter is 0 and server_rq=1, perform the access, go to ACK.
- Access: write stores latched dataW at latched address; read loads server_dataR from latched address. server_ack goes high on the same edge.
- ACK: server_ack held 1. On the edge sampling server_rq=0, server_ack goes 0 and state returns to IDLE.
- Bus inputs changing while in WAIT or ACK are ignored (latched copies used).
- server_rq dropping in WAIT: protocol violation; abort, no storage write, no dataR update, server_err=1 for one cycle, go to IDLE.
- server_dataR holds its last read value; writes never change it.

## Timing
- Reset values: server_ack=0, server_dataR=0, server_err=0, state IDLE, wait counter 0, all storage words 0.
- Latency: rq sampled high at edge N -> server_ack high after edge N+WAIT_CYCLES (after edge N with 0 waits).
- Release: rq sampled low at edge M in ACK -> server_ack low after edge M; a new rq can be sampled at edge M+1.
- Minimum transaction: 2 edges with 0 waits (rq capture/access, rq release).
- Read-after-write to same address in back-to-back transactions returns the new value.
- Reset mid-transaction (any state): ack, err, dataR cleared and storage zeroed asynchronously; no partial write completes.
- server_err asserted only in the cycle after the aborting edge; never coincident with server_ack.

## Configuration
- SERVER_WAIT_STATES_EN defined: WAIT state, wait counter and WAIT_CYCLES honoured as above.
- Not defined: WAIT state and counter removed; every access completes on the capturing edge (0-wait behaviour); server_err tied 0 since no abort window exists.

## Structure
- Shared package bus_arbiter_pkg: DATA_WIDTH/ADDR_WIDTH defaults, server FSM state encoding (IDLE, WAIT, ACK), RD/WR encoding of wr_ni.
- One sub-module: bus_server_regfile, the storage array with synchronous write, registered read and asynchronous active-low clear; bus_server_memory holds FSM, latches and counter.

## Test plan
- Reset then read address 4'h3 -> ack after WAIT_CYCLES=2 edges, server_dataR=8'h00.
- Write 8'hA5 to 4'h7, release, read 4'h7 -> second ack with server_dataR=8'hA5; dataR unchanged (8'h00) during the write's ack.
- Request held 5 cycles after ack -> server_ack stays 1 for all 5, falls on the edge sampling rq=0; next rq accepted one edge later.
- Drop rq during WAIT on a write of 8'h3C to 4'h2 -> server_err pulse of exactly one cycle, no ack, subsequent read of 4'h2 returns 8'h00.
- Change server_address/dataW during WAIT (write 8'h11 to 4'h1, bus switches to 4'h9/8'hFF) -> 4'h1 holds 8'h11, 4'h9 holds 8'h00.
- Assert reset while in ACK after writing 8'h5A to 4'hF -> ack falls immediately, read of 4'hF after reset returns 8'h00; with SERVER_WAIT_STATES_EN undefined, ack follows rq by one edge.
